hsv_core_flush_ctrl: RTL and testbench

Central flush sequencer for the core's execution units (alu, branch, mem, foo, ...). Broadcasts a level flush request to every unit, waits for all units to acknowledge entry, holds the flush for a minimum time, then releases it and waits for all units to acknowledge exit. Sits between the control unit (trap/jump redirect source) and every unit's flush_req/flush_ack pair. Also performs the mandatory post-reset flush.

---
 rtl/hsv_core_pkg.sv | 12 +
 rtl/hsv_flush_watchdog.sv | 32 +++
 rtl/hsv_core_flush_ctrl.sv | 168 ++++++++++++++++
 tb/tb_hsv_core_flush_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hsv_core_pkg.sv
// Shared types for the core flush sequencer: FSM state encoding and the canonical unit count.
package hsv_core_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2
    } flush_state_t;

    localparam int FLUSH_UNITS = 6;

endpackage

// File: rtl/hsv_flush_watchdog.sv
// Per-phase watchdog for the flush sequencer: counts cycles since the last clear and
// flags expiry once the phase has lasted TIMEOUT_CYCLES cycles.
module hsv_flush_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk_core,
    input  logic rst_core_n,
    input  logic i_clear,
    output logic o_expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    // Phase counter: cleared on phase entry, saturates at the limit.
    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (r_cnt != CNT_LIMIT) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_expired = (r_cnt == CNT_LIMIT);

endmodule

// File: rtl/hsv_core_flush_ctrl.sv
// Central flush sequencer: broadcasts a level flush request to all units and runs the
// HOLD/RELEASE handshake. Optional per-phase watchdog enabled by HSV_FLUSH_WATCHDOG_EN.
module hsv_core_flush_ctrl
    import hsv_core_pkg::*;
#(
    parameter int NUM_UNITS      = FLUSH_UNITS,
    parameter int MIN_HOLD       = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk_core,
    input  logic                 rst_core_n,
    input  logic                 flush_start,
    output logic                 flush_busy,
    output logic                 flush_done,
    output logic [NUM_UNITS-1:0] unit_flush_req,
    input  logic [NUM_UNITS-1:0] unit_flush_ack,
    output logic                 protocol_err,
    output logic                 flush_timeout
);

    localparam int HOLD_W = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MIN_HOLD - 1);

    if (MIN_HOLD < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("hsv_core_flush_ctrl: MIN_HOLD and TIMEOUT_CYCLES must be >= 1");
    end

    flush_state_t          r_state;
    flush_state_t          w_state_nxt;
    logic [HOLD_W-1:0]     r_hold_cnt;
    logic [HOLD_W-1:0]     w_hold_cnt_nxt;
    logic                  r_pending;
    logic                  w_pending_nxt;
    logic                  r_req;
    logic                  r_done;
    logic                  w_done_nxt;
    logic                  r_perr;
    logic                  w_perr_set;
    logic [NUM_UNITS-1:0]  r_ack_q;
    logic                  w_all_ack;
    logic                  w_none_ack;
    logic                  w_expired;

    assign w_all_ack  = &unit_flush_ack;
    assign w_none_ack = ~|unit_flush_ack;

`ifdef HSV_FLUSH_WATCHDOG_EN
    logic w_wd_clear;
    logic w_wd_expired;
    logic r_timeout;

    // Any state change (or idling) restarts the phase timer.
    assign w_wd_clear = (r_state == IDLE) || (w_state_nxt != r_state);

    hsv_flush_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_core   (clk_core),
        .rst_core_n (rst_core_n),
        .i_clear    (w_wd_clear),
        .o_expired  (w_wd_expired)
    );

    assign w_expired = w_wd_expired && (r_state != IDLE);

    // Sticky timeout flag.
    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            r_timeout <= 1'b0;
        end else if (w_expired) begin
            r_timeout <= 1'b1;
        end else begin
            r_timeout <= r_timeout;
        end
    end

    assign flush_timeout = r_timeout;
`else
    assign w_expired     = 1'b0;
    assign flush_timeout = 1'b0;
`endif

    // Next-state decode; a flush_start coinciding with the release exit is not lost.
    always_comb begin
        w_state_nxt    = r_state;
        w_hold_cnt_nxt = r_hold_cnt;
        w_pending_nxt  = r_pending;
        w_done_nxt     = 1'b0;
        case (r_state)
            IDLE: begin
                if (flush_start) begin
                    w_state_nxt    = HOLD;
                    w_hold_cnt_nxt = '0;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            HOLD: begin
                if (((r_hold_cnt == HOLD_LAST) && w_all_ack) || w_expired) begin
                    w_state_nxt = RELEASE;
                end else if (r_hold_cnt != HOLD_LAST) begin
                    w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt;
                end
            end
            RELEASE: begin
                if (w_none_ack || w_expired) begin
                    if (r_pending || flush_start) begin
                        w_state_nxt    = HOLD;
                        w_hold_cnt_nxt = '0;
                        w_pending_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end else if (flush_start) begin
                    w_pending_nxt = 1'b1;
                end else begin
                    w_pending_nxt = r_pending;
                end
            end
            default: begin
                w_state_nxt    = HOLD;
                w_hold_cnt_nxt = '0;
                w_pending_nxt  = 1'b0;
            end
        endcase
    end

    // Handshake rule checks against the previous-cycle ack snapshot.
    always_comb begin
        w_perr_set = 1'b0;
        case (r_state)
            IDLE:    w_perr_set = |unit_flush_ack;
            HOLD:    w_perr_set = |(r_ack_q & ~unit_flush_ack);
            RELEASE: w_perr_set = |(~r_ack_q & unit_flush_ack);
            default: w_perr_set = 1'b0;
        endcase
    end

    // State, counters and registered outputs; reset lands in HOLD for the post-reset flush.
    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            r_state    <= HOLD;
            r_hold_cnt <= '0;
            r_pending  <= 1'b0;
            r_req      <= 1'b1;
            r_done     <= 1'b0;
            r_perr     <= 1'b0;
            r_ack_q    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_pending  <= w_pending_nxt;
            r_req      <= (w_state_nxt == HOLD);
            r_done     <= w_done_nxt;
            r_perr     <= r_perr | w_perr_set;
            r_ack_q    <= unit_flush_ack;
        end
    end

    assign unit_flush_req = {NUM_UNITS{r_req}};
    assign flush_done     = r_done;
    assign protocol_err   = r_perr;
    assign flush_busy     = (r_state != IDLE);

endmodule

// File: tb/tb_hsv_core_flush_ctrl.sv
// Directed bench for hsv_core_flush_ctrl; units modelled as delayed echoes of the request.
module tb_hsv_core_flush_ctrl;

    localparam int NU = 6;

    logic          clk_core    = 1'b0;
    logic          rst_core_n  = 1'b0;
    logic          flush_start = 1'b0;
    logic          flush_busy;
    logic          flush_done;
    logic [NU-1:0] unit_flush_req;
    logic [NU-1:0] unit_flush_ack;
    logic          protocol_err;
    logic          flush_timeout;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            lat [NU];
    logic [NU-1:0] mask_low  = '0;
    logic [NU-1:0] mask_high = '0;
    logic [NU-1:0] model_ack;
    logic [NU-1:0] hist [4];

    hsv_core_flush_ctrl #(
        .NUM_UNITS      (NU),
        .MIN_HOLD       (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_core       (clk_core),
        .rst_core_n     (rst_core_n),
        .flush_start    (flush_start),
        .flush_busy     (flush_busy),
        .flush_done     (flush_done),
        .unit_flush_req (unit_flush_req),
        .unit_flush_ack (unit_flush_ack),
        .protocol_err   (protocol_err),
        .flush_timeout  (flush_timeout)
    );

    always #5 clk_core = ~clk_core;

    // Request history: latency 1 = combinational echo, latency L = req delayed L-1 cycles.
    always @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            for (int i = 0; i < 4; i++) hist[i] <= '0;
        end else begin
            hist[0] <= unit_flush_req;
            for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
        end
    end

    always_comb begin
        model_ack = '0;
        for (int i = 0; i < NU; i++) begin
            if (lat[i] <= 1) model_ack[i] = unit_flush_req[i];
            else             model_ack[i] = hist[lat[i]-2][i];
        end
    end

    assign unit_flush_ack = (model_ack & ~mask_low) | mask_high;

    task automatic set_lat_all(input int l);
        for (int i = 0; i < NU; i++) lat[i] = l;
    endtask

    task automatic test_reset();
        logic [4:0] e_req, e_busy, e_done;
        e_req = 5'b00001; e_busy = 5'b00111; e_done = 5'b01000;
        rst_core_n = 1'b0; flush_start = 1'b0; mask_low = '0; mask_high = '0;
        set_lat_all(2);
        repeat (2) @(negedge clk_core);
        n_checks++;
        if ({unit_flush_req, flush_busy, flush_done, protocol_err, flush_timeout} !==
            {{NU{1'b1}}, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: got req=%b busy=%b done=%b perr=%b tmo=%b, expected req=111111 busy=1 done=0 perr=0 tmo=0",
                     unit_flush_req, flush_busy, flush_done, protocol_err, flush_timeout);
        end
        rst_core_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk_core);
            n_checks++;
            if ({unit_flush_req, flush_busy, flush_done} !== {{NU{e_req[k-1]}}, e_busy[k-1], e_done[k-1]}) begin
                n_fail++;
                $display("FAIL post_reset cyc%0d: got req=%b busy=%b done=%b, expected req=%b busy=%b done=%b",
                         k, unit_flush_req, flush_busy, flush_done, {NU{e_req[k-1]}}, e_busy[k-1], e_done[k-1]);
            end
        end
    endtask

    task automatic test_single_flush();
        logic [9:0] e_req, e_busy, e_done;
        e_req = 10'b0000001111; e_busy = 10'b0011111111; e_done = 10'b0100000000;
        lat = '{1, 2, 3, 4, 1, 2};
        repeat (3) @(negedge clk_core);
        n_checks++;
        if (flush_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: got busy=%b, expected 0", flush_busy);
        end
        flush_start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk_core);
            flush_start = 1'b0;
            n_checks++;
            if ({unit_flush_req, flush_busy, flush_done} !== {{NU{e_req[k-1]}}, e_busy[k-1], e_done[k-1]}) begin
                n_fail++;
                $display("FAIL single cyc%0d: got req=%b busy=%b done=%b, expected req=%b busy=%b done=%b",
                         k, unit_flush_req, flush_busy, flush_done, {NU{e_req[k-1]}}, e_busy[k-1], e_done[k-1]);
            end
        end
        n_checks++;
        if (protocol_err !== 1'b0) begin
            n_fail++;
            $display("FAIL single_perr: got %b, expected 0", protocol_err);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] e_req, e_busy, e_done;
        e_req = 10'b0000110011; e_busy = 10'b0011111111; e_done = 10'b0100000000;
        set_lat_all(2);
        repeat (3) @(negedge clk_core);
        flush_start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk_core);
            flush_start = (k == 3);
            n_checks++;
            if ({unit_flush_req, flush_busy, flush_done} !== {{NU{e_req[k-1]}}, e_busy[k-1], e_done[k-1]}) begin
                n_fail++;
                $display("FAIL b2b cyc%0d: got req=%b busy=%b done=%b, expected req=%b busy=%b done=%b",
                         k, unit_flush_req, flush_busy, flush_done, {NU{e_req[k-1]}}, e_busy[k-1], e_done[k-1]);
            end
        end
    endtask

    task automatic test_protocol_idle();
        logic [5:0] e_busy, e_done;
        e_busy = 6'b001111; e_done = 6'b010000;
        set_lat_all(2);
        repeat (3) @(negedge clk_core);
        mask_high = 6'b001000;
        @(negedge clk_core);
        mask_high = '0;
        n_checks++;
        if ({protocol_err, flush_busy, unit_flush_req} !== {1'b1, 1'b0, {NU{1'b0}}}) begin
            n_fail++;
            $display("FAIL perr_idle: got perr=%b busy=%b req=%b, expected perr=1 busy=0 req=000000",
                     protocol_err, flush_busy, unit_flush_req);
        end
        flush_start = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk_core);
            flush_start = 1'b0;
            n_checks++;
            if ({protocol_err, flush_busy, flush_done} !== {1'b1, e_busy[k-1], e_done[k-1]}) begin
                n_fail++;
                $display("FAIL perr_sticky cyc%0d: got perr=%b busy=%b done=%b, expected perr=1 busy=%b done=%b",
                         k, protocol_err, flush_busy, flush_done, e_busy[k-1], e_done[k-1]);
            end
        end
    endtask

    task automatic test_watchdog();
        logic er, eb, ed, et;
        bit   seen;
        set_lat_all(2);
        mask_low = 6'b000001;
        repeat (3) @(negedge clk_core);
        flush_start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk_core);
            flush_start = 1'b0;
`ifdef HSV_FLUSH_WATCHDOG_EN
            er = (k <= 16); eb = (k <= 18); ed = (k == 19); et = (k >= 17);
`else
            er = 1'b1; eb = 1'b1; ed = 1'b0; et = 1'b0;
`endif
            n_checks++;
            if ({unit_flush_req, flush_busy, flush_done, flush_timeout} !== {{NU{er}}, eb, ed, et}) begin
                n_fail++;
                $display("FAIL watchdog cyc%0d: got req=%b busy=%b done=%b tmo=%b, expected req=%b busy=%b done=%b tmo=%b",
                         k, unit_flush_req, flush_busy, flush_done, flush_timeout, {NU{er}}, eb, ed, et);
            end
        end
        mask_low = '0;
`ifndef HSV_FLUSH_WATCHDOG_EN
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk_core);
            seen = flush_done;
        end
        n_checks++;
        if (seen !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_recover: got done=0 within 20 cycles, expected done=1");
        end
`endif
    endtask

    task automatic test_reset_mid();
        set_lat_all(2);
        repeat (2) @(negedge clk_core);
        mask_high = 6'b000100;
        @(negedge clk_core);
        mask_high = '0;
        flush_start = 1'b1;
        @(negedge clk_core);
        flush_start = 1'b0;
        repeat (2) @(negedge clk_core);
        n_checks++;
        if ({unit_flush_req, flush_busy, protocol_err} !== {{NU{1'b0}}, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL mid_release: got req=%b busy=%b perr=%b, expected req=000000 busy=1 perr=1",
                     unit_flush_req, flush_busy, protocol_err);
        end
        rst_core_n = 1'b0;
        #1;
        n_checks++;
        if ({unit_flush_req, flush_busy, flush_done, protocol_err, flush_timeout} !==
            {{NU{1'b1}}, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_reset: got req=%b busy=%b done=%b perr=%b tmo=%b, expected req=111111 busy=1 done=0 perr=0 tmo=0",
                     unit_flush_req, flush_busy, flush_done, protocol_err, flush_timeout);
        end
        test_reset();
    endtask

    task automatic test_protocol_hold();
        bit seen;
        lat = '{4, 2, 2, 2, 2, 2};
        repeat (3) @(negedge clk_core);
        flush_start = 1'b1;
        @(negedge clk_core);
        flush_start = 1'b0;
        repeat (2) @(negedge clk_core);
        n_checks++;
        if ({protocol_err, unit_flush_req[1], unit_flush_ack[1]} !== 3'b011) begin
            n_fail++;
            $display("FAIL hold_pre: got perr=%b req1=%b ack1=%b, expected perr=0 req1=1 ack1=1",
                     protocol_err, unit_flush_req[1], unit_flush_ack[1]);
        end
        mask_low = 6'b000010;
        @(negedge clk_core);
        mask_low = '0;
        n_checks++;
        if ({protocol_err, flush_busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL hold_fall: got perr=%b busy=%b, expected perr=1 busy=1", protocol_err, flush_busy);
        end
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk_core);
            seen = flush_done;
        end
        n_checks++;
        if ({seen, protocol_err} !== 2'b11) begin
            n_fail++;
            $display("FAIL hold_finish: got done_seen=%b perr=%b, expected done_seen=1 perr=1", seen, protocol_err);
        end
    endtask

    initial begin
        set_lat_all(2);
        test_reset();
        test_single_flush();
        test_back_to_back();
        test_protocol_idle();
        test_watchdog();
        test_reset_mid();
        test_protocol_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
